// File: rtl/inst_encoder.sv
// inst_encoder: packs LC-3b instruction fields into a 16-bit word and queues
// it in a DEPTH-entry FIFO with a valid/ready output toward fetch/IR load.
// Optional feature macro: INST_ENC_PARITY_EN adds out_parity (even parity of
// the packed word, computed at push and stored as a 17th bit per entry).
module inst_encoder #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [3:0]               opcode,
    input  logic [2:0]               dest,
    input  logic [2:0]               sr1,
    input  logic [2:0]               sr2,
    input  logic                     bit5,
    input  logic                     bit4,
    input  logic                     bit11,
    input  logic [4:0]               imm5,
    input  logic [3:0]               imm4,
    input  logic [5:0]               offset6,
    input  logic [8:0]               offset9,
    input  logic [10:0]              offset11,
    input  logic [7:0]               trapvect8,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [15:0]              out_word,
`ifdef INST_ENC_PARITY_EN
    output logic                     out_parity,
`endif
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
`ifdef INST_ENC_PARITY_EN
    localparam int EW = 17;
`else
    localparam int EW = 16;
`endif

    logic [15:0]   packed_w;
    logic [EW-1:0] entry_w;
    logic [EW-1:0] head_w;
    logic [EW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push, pop;

    // Field packing: opcode on top, fields not used by the opcode stay zero.
    always_comb begin
        packed_w = {opcode, 12'h000};
        case (opcode)
            4'b0001, 4'b0101:                       // ADD / AND
                packed_w[11:0] = bit5 ? {dest, sr1, 1'b1, imm5}
                                      : {dest, sr1, 1'b0, 2'b00, sr2};
            4'b1001:                                // NOT
                packed_w[11:0] = {dest, sr1, 6'b111111};
            4'b0000, 4'b1110:                       // BR / LEA
                packed_w[11:0] = {dest, offset9};
            4'b0010, 4'b0110, 4'b1010,
            4'b0011, 4'b0111, 4'b1011:              // loads / stores
                packed_w[11:0] = {dest, sr1, offset6};
            4'b1100:                                // JMP
                packed_w[11:0] = {3'b000, sr1, 6'b000000};
            4'b0100:                                // JSR / JSRR
                packed_w[11:0] = bit11 ? {1'b1, offset11}
                                       : {3'b000, sr1, 6'b000000};
            4'b1101:                                // SHF
                packed_w[11:0] = {dest, sr1, bit5, bit4, imm4};
            4'b1111:                                // TRAP
                packed_w[11:0] = {4'h0, trapvect8};
            default: ;                              // RTI: low bits zero
        endcase
    end

`ifdef INST_ENC_PARITY_EN
    assign entry_w = {^packed_w, packed_w};
`else
    assign entry_w = packed_w;
`endif

    assign in_ready  = (count_q != CW'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;

    // Storage is not reset; the count gates everything visible downstream.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= entry_w;
    end

    assign head_w   = mem_q[rd_ptr_q];
    assign out_word = out_valid ? head_w[15:0] : 16'h0000;
`ifdef INST_ENC_PARITY_EN
    assign out_parity = out_valid ? head_w[16] : 1'b0;
`endif
    assign count = count_q;

    // Next-state for pointers and occupancy; flush wins over push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: ;
            endcase
        end
    end

    // Pointer/count registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: tb/tb_inst_encoder.sv
// Directed bench for inst_encoder (DEPTH=4).
module tb_inst_encoder;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [3:0]  opcode, imm4;
    logic [2:0]  dest, sr1, sr2;
    logic        bit5, bit4, bit11;
    logic [4:0]  imm5;
    logic [5:0]  offset6;
    logic [8:0]  offset9;
    logic [10:0] offset11;
    logic [7:0]  trapvect8;
    logic [15:0] out_word;
    logic [2:0]  count;
`ifdef INST_ENC_PARITY_EN
    logic        out_parity;
`endif

    int ncmp = 0;
    int nerr = 0;

    inst_encoder #(.DEPTH(4)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .dest(dest), .sr1(sr1), .sr2(sr2),
        .bit5(bit5), .bit4(bit4), .bit11(bit11),
        .imm5(imm5), .imm4(imm4), .offset6(offset6), .offset9(offset9),
        .offset11(offset11), .trapvect8(trapvect8),
        .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
`ifdef INST_ENC_PARITY_EN
        .out_parity(out_parity),
`endif
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fld(input logic [3:0] op, input logic [2:0] d, input logic [2:0] s1,
                       input logic [2:0] s2, input logic b5, input logic b4, input logic b11,
                       input logic [4:0] i5, input logic [3:0] i4, input logic [5:0] o6,
                       input logic [8:0] o9, input logic [10:0] o11, input logic [7:0] tv);
        opcode = op; dest = d; sr1 = s1; sr2 = s2; bit5 = b5; bit4 = b4; bit11 = b11;
        imm5 = i5; imm4 = i4; offset6 = o6; offset9 = o9; offset11 = o11; trapvect8 = tv;
    endtask

    // push one word into an empty FIFO, check it at the head, then drain it
    task automatic push_pop(input string tag, input logic [15:0] exp);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk({tag, "_word"}, out_word, exp);
        chk({tag, "_valid"}, out_valid, 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_drained"}, count, 0);
    endtask

    task automatic trap(input logic [7:0] tv);
        fld(4'b1111, 3'd0, 3'd0, 3'd0, 0, 0, 0, 5'd0, 4'd0, 6'd0, 9'd0, 11'd0, tv);
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        trap(8'h00);
        #12;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_word", out_word, 16'h0000);
        chk("rst_count", count, 0);
        @(negedge clk);
        reset = 1'b0;
        tick();

        // ADD R1,R2,#-1 with latency and count check
        fld(4'b0001, 3'd1, 3'd2, 3'd6, 1, 1, 1, 5'b11111, 4'hF, 6'h3F, 9'h1FF, 11'h7FF, 8'hFF);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("add_imm_word", out_word, 16'h12BF);
        chk("add_imm_valid", out_valid, 1);
        chk("add_imm_count", count, 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("add_imm_empty_word", out_word, 16'h0000);
        chk("add_imm_empty_valid", out_valid, 0);

        // encodings, with unused fields driven with junk
        fld(4'b0001, 3'd3, 3'd4, 3'd5, 0, 1, 1, 5'b10101, 4'hF, 6'h3F, 9'h1FF, 11'h7FF, 8'hFF);
        push_pop("add_reg", 16'h1705);
        fld(4'b1001, 3'd0, 3'd1, 3'd7, 0, 1, 1, 5'h1F, 4'hF, 6'h00, 9'h1FF, 11'h7FF, 8'hFF);
        push_pop("not", 16'h907F);
        fld(4'b1111, 3'd7, 3'd7, 3'd7, 1, 1, 1, 5'h1F, 4'hF, 6'h3F, 9'h1FF, 11'h7FF, 8'h25);
        push_pop("trap", 16'hF025);
        fld(4'b0100, 3'd7, 3'd7, 3'd7, 1, 1, 1, 5'h1F, 4'hF, 6'h3F, 9'h1FF, 11'h7FF, 8'hFF);
        push_pop("jsr", 16'h4FFF);
        fld(4'b0100, 3'd5, 3'd3, 3'd7, 1, 1, 0, 5'h1F, 4'hF, 6'h3F, 9'h1FF, 11'h7FF, 8'hFF);
        push_pop("jsrr", 16'h40C0);
        fld(4'b1101, 3'd2, 3'd2, 3'd7, 1, 0, 1, 5'h1F, 4'd3, 6'h3F, 9'h1FF, 11'h7FF, 8'hFF);
        push_pop("shf", 16'hD4A3);
        fld(4'b0000, 3'd7, 3'd5, 3'd7, 1, 1, 1, 5'h1F, 4'hF, 6'h3F, 9'h1FF, 11'h7FF, 8'hFF);
        push_pop("br", 16'h0FFF);
        fld(4'b0110, 3'd2, 3'd3, 3'd7, 1, 1, 1, 5'h1F, 4'hF, 6'h2A, 9'h1FF, 11'h7FF, 8'hFF);
        push_pop("ldw", 16'h64EA);
        fld(4'b1100, 3'd5, 3'd7, 3'd7, 1, 1, 1, 5'h1F, 4'hF, 6'h3F, 9'h1FF, 11'h7FF, 8'hFF);
        push_pop("jmp", 16'hC1C0);
        fld(4'b1000, 3'd7, 3'd7, 3'd7, 1, 1, 1, 5'h1F, 4'hF, 6'h3F, 9'h1FF, 11'h7FF, 8'hFF);
        push_pop("rti", 16'h8000);

        // fill to full, fifth push held
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            trap(8'h10 + 8'(i));
            tick();
        end
        trap(8'h14);
        tick();
        tick();
        chk("full_count", count, 4);
        chk("full_in_ready", in_ready, 0);
        chk("full_head", out_word, 16'hF010);
        out_ready = 1'b1;
        tick();
        chk("pop1_count", count, 3);
        chk("pop1_in_ready", in_ready, 1);
        chk("pop1_head", out_word, 16'hF011);
        tick();
        in_valid = 1'b0;
        chk("pop2_count", count, 3);
        chk("pop2_head", out_word, 16'hF012);
        tick();
        chk("pop3_head", out_word, 16'hF013);
        tick();
        chk("pop4_head", out_word, 16'hF014);
        chk("pop4_count", count, 1);
        tick();
        chk("drain_count", count, 0);
        chk("drain_valid", out_valid, 0);
        out_ready = 1'b0;

        // streaming one word per cycle across pointer wrap
        in_valid = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            trap(8'h40 + 8'(i));
            tick();
            chk($sformatf("stream_word%0d", i), out_word, 32'hF040 + i);
            chk($sformatf("stream_count%0d", i), count, 1);
        end
        in_valid = 1'b0;
        tick();
        out_ready = 1'b0;
        chk("stream_end_count", count, 0);

        // asynchronous reset between edges
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            trap(8'h60 + 8'(i));
            tick();
        end
        in_valid = 1'b0;
        chk("pre_areset_count", count, 3);
        #2;
        reset = 1'b1;
        #1;
        chk("areset_count", count, 0);
        chk("areset_valid", out_valid, 0);
        chk("areset_word", out_word, 16'h0000);
        chk("areset_in_ready", in_ready, 1);
`ifdef INST_ENC_PARITY_EN
        chk("areset_parity", out_parity, 0);
`endif
        @(negedge clk);
        reset = 1'b0;

        // flush with simultaneous push
        in_valid = 1'b1;
        trap(8'h70);
        tick();
        trap(8'h71);
        tick();
        chk("pre_flush_count", count, 2);
        trap(8'h77);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_count", count, 0);
        chk("flush_valid", out_valid, 0);
        trap(8'h88);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("post_flush_head", out_word, 16'hF088);
        chk("post_flush_count", count, 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("post_flush_drain", count, 0);

`ifdef INST_ENC_PARITY_EN
        fld(4'b0001, 3'd1, 3'd2, 3'd0, 1, 0, 0, 5'b11111, 4'h0, 6'h00, 9'h000, 11'h000, 8'h00);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("par_12bf", out_parity, 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("par_empty", out_parity, 0);
        fld(4'b0000, 3'd0, 3'd0, 3'd0, 0, 0, 0, 5'd0, 4'd0, 6'd0, 9'd0, 11'd0, 8'd0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("par_zero_valid", out_valid, 1);
        chk("par_zero", out_parity, 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule

// File: doc/inst_encoder.md
Name: inst_encoder

Overview:
- Reverse of the instruction register's field decode: accepts LC-3b instruction fields plus opcode and packs them into a 16-bit lc3b_word.
- Each packed word is queued in a small FIFO and presented on a valid/ready output toward fetch/IR load.
- Used for microcode and trap-sequence instruction injection, and as a stimulus source for decode verification.

Parameters:
- DEPTH, 4, FIFO entries; power of 2, minimum 2.

Ports:
- clk  in  1  clock, all state on posedge.
- reset  in  1  asynchronous, active-high; clears all state.
- flush  in  1  synchronous FIFO clear.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  encoder can accept; equals !full.
- opcode  in  4  lc3b_opcode.
- dest  in  3  dest register, or nzp for BR.
- sr1  in  3  source/base register.
- sr2  in  3  second source register.
- bit5  in  1  immediate select (ADD/AND), or SHF D bit.
- bit4  in  1  SHF A bit.
- bit11  in  1  JSR/JSRR select.
- imm5  in  5  ADD/AND immediate.
- imm4  in  4  SHF amount.
- offset6  in  6  memory-op offset.
- offset9  in  9  BR/LEA offset.
- offset11  in  11  JSR offset.
- trapvect8  in  8  trap vector.
- out_valid  out  1  head word valid.
- out_ready  in  1  consumer accepts head.
- out_word  out  16  packed instruction at FIFO head.
- count  out  $clog2(DEPTH)+1  entries held.

Behaviour:
- Packing is combinational from the inputs. Bits [15:12] = opcode. Fields not listed for an opcode are forced to 0.
  - ADD 0001 / AND 0101: [11:9]=dest, [8:6]=sr1, [5]=bit5.
    - bit5=1: [4:0]=imm5.
    - bit5=0: [4:3]=00, [2:0]=sr2.
  - NOT 1001: dest, sr1, [5:0]=111111.
  - BR 0000: [11:9]=dest, [8:0]=offset9.
  - LEA 1110: [11:9]=dest, [8:0]=offset9.
  - LDB 0010 / LDW 0110 / LDI 1010 / STB 0011 / STW 0111 / STI 1011: dest, sr1, [5:0]=offset6.
  - JMP 1100: [8:6]=sr1.
  - JSR 0100: [11]=bit11.
    - bit11=1: [10:0]=offset11.
    - bit11=0: [8:6]=sr1.
  - SHF 1101: dest, sr1, [5]=bit5, [4]=bit4, [3:0]=imm4.
  - TRAP 1111: [7:0]=trapvect8.
  - RTI 1000: [11:0]=0.
- Push when in_valid && in_ready at posedge. The packed word is written at wr_ptr.
- Pop when out_valid && out_ready at posedge. rd_ptr advances.
- out_word = mem[rd_ptr], driven from registered storage. out_valid = (count != 0).
  - Latency: a word pushed at edge N is visible on out_word/out_valid after edge N.
- Push and pop in the same cycle: both happen, count unchanged. Legal whenever not full and not empty.
- Full (count==DEPTH):
  - in_ready=0. in_valid is ignored and the producer holds.
  - No push-through on simultaneous pop; in_ready rises the cycle after the pop.
- Empty:
  - out_valid=0, out_word=0.
  - out_ready is ignored.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- flush at posedge: pointers and count cleared. flush dominates a push or pop in the same cycle; the pushed word is dropped.
- reset (async, any time, including mid-transfer):
  - Immediately clears pointers and count; out_valid=0, out_word=0, in_ready=1.
  - FIFO storage contents need not be cleared.
- Reset values: in_ready=1, out_valid=0, out_word=16'h0000, count=0.

Optional Feature:
- Macro INST_ENC_PARITY_EN.
- Defined:
  - Extra output port out_parity (1 bit) = even parity (XOR of all 16 bits) of the packed word.
  - Parity is computed at push and stored alongside the word (17-bit entries).
  - out_parity=0 when empty and after reset.
- Undefined: port and storage bit absent; 16-bit entries.

Test Plan:
- ADD R1,R2,#-1: opcode=0001, dest=1, sr1=2, bit5=1, imm5=11111, FIFO empty -> next cycle out_valid=1, out_word=0x12BF, count=1.
- ADD register form: dest=3, sr1=4, sr2=5, bit5=0, imm5=10101 -> 0x1705. Also check: NOT R0,R1 -> 0x907F; TRAP x25 with dest=7 -> 0xF025; JSR bit11=1, offset11=0x7FF -> 0x4FFF; JSRR bit11=0, sr1=3 -> 0x40C0; SHF dest=2, sr1=2, bit5=1, bit4=0, imm4=3 -> 0xD4A3.
- DEPTH=4, out_ready=0, five pushes attempted -> count=4, in_ready=0, fifth held. Then out_ready=1 -> words drain in push order; in_ready=1 the cycle after the first pop; fifth accepted.
- Continuous stream of in_valid=1 and out_ready=1 at one word per cycle -> count stays 1, every word delivered exactly once across pointer wrap (at least 10 words).
- count=3, assert reset between edges -> out_valid=0 and count=0 without waiting for a clock. flush asserted with a simultaneous push -> count=0, pushed word absent.
- With INST_ENC_PARITY_EN defined: push 0x12BF -> out_parity=1; push 0x0000 (BR, all fields 0) -> out_parity=0.
